// File: rtl/datapath_gen.sv
// Processor datapath: register file, ALU, PC/LR/IR/ALUOUT, flags, interrupt entry/return, optional multiplier.
// Latency: ALU and bus are combinational, registers update on the next Clock edge, a multiply takes WIDTH+1 cycles.
// Backpressure: none on the datapath; the control FSM waits while MulBusy is high and uses the one-cycle MulDone pulse.
//
// Ports:
//   Clock, nReset          rising-edge clock, asynchronous active-low reset
//   SysBus                 shared tristate bus; driven by the enabled sources (MemEn/PcEn/LrEn/AluEn)
//   DataIn                 memory read data
//   IrWe / Ir              instruction register load / value
//   AluOp, Op1Sel, Op2Sel  ALU function and operand selection
//   Rs1Sel, RwSel, WdSel   register file read/write index and write-data selection
//   RegWe, FlagWe / Flags  register file and flag write enables / registered {N,Z,C,V}
//   PcSel, PcWe, PcEn      PC source, write, bus drive
//   LrSel, LrWe, LrEn      LR source, write, bus drive
//   AluWe, AluEn           ALUOUT write, bus drive
//   IntEnter, IntReturn    interrupt strobes / IntActive status
//   MulStart, MulBusy, MulDone  multiplier handshake
//   BusConflict            more than one bus driver enabled
//
// Build option: define DATAPATH_GEN_MUL_EN to include the shift-add multiplier.
// Without it MulBusy/MulDone stay low, MulStart is ignored and WdSel 2/3 write zero.

module datapath_gen #(
  parameter int          WIDTH      = 16,
  parameter logic [15:0] INT_VECTOR = 16'h0010
) (
  input  logic             Clock,
  input  logic             nReset,
  inout  wire  [WIDTH-1:0] SysBus,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             MemEn,
  input  logic             IrWe,
  output logic [WIDTH-1:0] Ir,
  input  logic [3:0]       AluOp,
  input  logic             Op1Sel,
  input  logic [1:0]       Op2Sel,
  input  logic             Rs1Sel,
  input  logic [1:0]       RwSel,
  input  logic [1:0]       WdSel,
  input  logic             RegWe,
  input  logic             FlagWe,
  output logic [3:0]       Flags,
  input  logic [2:0]       PcSel,
  input  logic             PcWe,
  input  logic             PcEn,
  input  logic             LrSel,
  input  logic             LrWe,
  input  logic             LrEn,
  input  logic             AluWe,
  input  logic             AluEn,
  input  logic             IntEnter,
  input  logic             IntReturn,
  output logic             IntActive,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone,
  output logic             BusConflict
);

  localparam logic [WIDTH-1:0] VEC = WIDTH'(INT_VECTOR);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Architectural state
  logic [WIDTH-1:0] r_pc, r_lr, r_ir, r_aluout;
  logic [WIDTH-1:0] r_regs [0:7];
  logic [3:0]       r_flags, r_saved_flags;
  logic             r_int_active;

  // Combinational nets
  logic [WIDTH-1:0] w_bus, w_bus_val;
  logic             w_bus_any;
  logic [2:0]       w_en_cnt;
  logic [2:0]       w_rs1, w_rs2, w_rw;
  logic [WIDTH-1:0] w_rd1, w_rd2, w_op_a, w_op_b;
  logic [WIDTH-1:0] w_alu_b, w_alu_res;
  logic             w_alu_cin, w_alu_c, w_alu_v;
  logic [WIDTH:0]   w_alu_sum;
  logic [3:0]       w_alu_flags;
  logic [WIDTH-1:0] w_pc_inc, w_pc_nxt, w_lr_nxt, w_wd;
  logic [WIDTH-1:0] w_mul_lo, w_mul_hi;
  logic             w_enter, w_return;

  // ---------------- Bus ----------------
  // Sources are OR-ed; the value is only meaningful with a single driver.
  assign w_bus_val = ({WIDTH{MemEn}} & DataIn) | ({WIDTH{PcEn}} & r_pc) |
                     ({WIDTH{LrEn}}  & r_lr)   | ({WIDTH{AluEn}} & r_aluout);
  assign w_bus_any = MemEn | PcEn | LrEn | AluEn;
  assign SysBus    = w_bus_any ? w_bus_val : {WIDTH{1'bz}};
  assign w_bus     = SysBus;

  assign w_en_cnt    = {2'b00, MemEn} + {2'b00, PcEn} + {2'b00, LrEn} + {2'b00, AluEn};
  assign BusConflict = (w_en_cnt > 3'd1);

  // ---------------- Register file ----------------
  assign w_rs1 = Rs1Sel ? r_ir[7:5] : r_ir[10:8];
  assign w_rs2 = r_ir[4:2];
  assign w_rd1 = r_regs[w_rs1];
  assign w_rd2 = r_regs[w_rs2];

  always_comb begin
    w_rw = 3'd7;
    case (RwSel)
      2'd1:    w_rw = r_ir[10:8];
      2'd2:    w_rw = r_ir[7:5];
      default: w_rw = 3'd7;
    endcase
  end

  always_comb begin
    w_wd = w_alu_res;
    case (WdSel)
      2'd0:    w_wd = w_alu_res;
      2'd1:    w_wd = w_bus;
      2'd2:    w_wd = w_mul_lo;
      default: w_wd = w_mul_hi;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (RegWe) begin
      r_regs[w_rw] <= w_wd;
    end
  end

  // ---------------- ALU ----------------
  assign w_op_a = Op1Sel ? r_pc : w_rd1;

  always_comb begin
    w_op_b = '0;
    case (Op2Sel)
      2'd0:    w_op_b = w_rd2;
      2'd1:    w_op_b = {{(WIDTH-5){r_ir[4]}}, r_ir[4:0]};
      2'd2:    w_op_b = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
      default: w_op_b = '0;
    endcase
  end

  // Subtraction is A + ~B + carry-in, so the carry out doubles as "no borrow".
  always_comb begin
    w_alu_b   = w_op_b;
    w_alu_cin = 1'b0;
    case (AluOp)
      4'd1:    w_alu_cin = r_flags[1];
      4'd2:    begin w_alu_b = ~w_op_b; w_alu_cin = 1'b1;       end
      4'd3:    begin w_alu_b = ~w_op_b; w_alu_cin = r_flags[1]; end
      default: ;
    endcase
    w_alu_sum = {1'b0, w_op_a} + {1'b0, w_alu_b} + {{WIDTH{1'b0}}, w_alu_cin};

    w_alu_res = w_op_a;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (AluOp)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        w_alu_res = w_alu_sum[WIDTH-1:0];
        w_alu_c   = w_alu_sum[WIDTH];
        // Overflow: both addends share a sign that the result does not.
        w_alu_v   = (w_op_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                    (w_alu_sum[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      4'd4:  w_alu_res = w_op_a & w_op_b;
      4'd5:  w_alu_res = w_op_a | w_op_b;
      4'd6:  w_alu_res = w_op_a ^ w_op_b;
      4'd7:  w_alu_res = ~w_op_a;
      4'd8:  begin w_alu_res = {w_op_a[WIDTH-2:0], 1'b0};         w_alu_c = w_op_a[WIDTH-1]; end
      4'd9:  begin w_alu_res = {1'b0, w_op_a[WIDTH-1:1]};         w_alu_c = w_op_a[0];       end
      4'd10: begin w_alu_res = {w_op_a[WIDTH-1], w_op_a[WIDTH-1:1]}; w_alu_c = w_op_a[0];    end
      4'd11: w_alu_res = w_op_b;
      default: w_alu_res = w_op_a;
    endcase
    w_alu_flags = {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
  end

  // ---------------- PC / LR / flags / interrupts ----------------
  assign w_pc_inc = r_pc + ONE;
  assign w_lr_nxt = LrSel ? w_bus : w_pc_inc;

  always_comb begin
    w_pc_nxt = r_pc;
    case (PcSel)
      3'd0:    w_pc_nxt = w_pc_inc;
      3'd1:    w_pc_nxt = r_lr;
      3'd2:    w_pc_nxt = w_alu_res;
      3'd3:    w_pc_nxt = w_bus;
      3'd4:    w_pc_nxt = VEC;
      default: w_pc_nxt = r_pc;
    endcase
  end

  // Only one strobe can take effect: entry needs IntActive=0, return needs IntActive=1.
  assign w_enter  = IntEnter  & ~r_int_active;
  assign w_return = IntReturn &  r_int_active;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_pc          <= '0;
      r_lr          <= '0;
      r_flags       <= '0;
      r_saved_flags <= '0;
      r_int_active  <= 1'b0;
    end else if (w_enter) begin
      r_lr          <= r_pc;
      r_pc          <= VEC;
      r_saved_flags <= r_flags;
      r_int_active  <= 1'b1;
    end else if (w_return) begin
      r_pc          <= r_lr;
      r_flags       <= r_saved_flags;
      r_int_active  <= 1'b0;
    end else begin
      if (PcWe)   r_pc    <= w_pc_nxt;
      if (LrWe)   r_lr    <= w_lr_nxt;
      if (FlagWe) r_flags <= w_alu_flags;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_ir     <= '0;
      r_aluout <= '0;
    end else begin
      if (IrWe)  r_ir     <= w_bus;
      if (AluWe) r_aluout <= w_alu_res;
    end
  end

  assign Ir        = r_ir;
  assign Flags     = r_flags;
  assign IntActive = r_int_active;

  // ---------------- Multiplier ----------------
`ifdef DATAPATH_GEN_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

  mul_state_t           r_mul_state, w_mul_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, w_acc_step;
  logic [WIDTH-1:0]     r_mplier, r_mul_lo, r_mul_hi;
  logic [CNT_W-1:0]     r_cnt;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_mul_state <= MUL_IDLE;
    else         r_mul_state <= w_mul_state_nxt;
  end

  always_comb begin
    w_mul_state_nxt = r_mul_state;
    MulBusy         = 1'b0;
    MulDone         = 1'b0;
    case (r_mul_state)
      MUL_IDLE: if (MulStart) w_mul_state_nxt = MUL_RUN;
      MUL_RUN: begin
        MulBusy = 1'b1;
        if (r_cnt == '0) w_mul_state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        MulDone         = 1'b1;
        w_mul_state_nxt = MUL_IDLE;
      end
      default: w_mul_state_nxt = MUL_IDLE;
    endcase
  end

  // Operands are captured at start, so later register writes cannot disturb a running multiply.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mul_lo <= '0;
      r_mul_hi <= '0;
    end else begin
      case (r_mul_state)
        MUL_IDLE: if (MulStart) begin
          r_mcand  <= {{WIDTH{1'b0}}, w_op_a};
          r_mplier <= w_op_b;
          r_acc    <= '0;
          r_cnt    <= CNT_W'(WIDTH-1);
        end
        MUL_RUN: begin
          r_acc    <= w_acc_step;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) {r_mul_hi, r_mul_lo} <= w_acc_step;
        end
        default: ;
      endcase
    end
  end

  assign w_mul_lo = r_mul_lo;
  assign w_mul_hi = r_mul_hi;
`else
  logic w_unused_mul_start;
  assign w_unused_mul_start = MulStart;
  assign w_mul_lo = '0;
  assign w_mul_hi = '0;
  assign MulBusy  = 1'b0;
  assign MulDone  = 1'b0;
`endif

endmodule

// File: doc/datapath_gen.md
Name: datapath_gen

Overview:
Parametrised successor to the 16-bit processor datapath.
- Holds the 8-entry register file, ALU, PC, LR, IR and ALUOUT registers, and drives the shared tristate SysBus.
- Adds: generic data width, registered flags, single-cycle interrupt entry/return with flag save, and an optional multi-cycle multiplier with busy/done handshake.
- Controlled cycle-by-cycle by the control FSM.

Parameters:
- WIDTH, 16, datapath/bus width; must be >= 16.
- INT_VECTOR, 16'h0010, PC load value on interrupt entry; zero-extended to WIDTH.

Ports:
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- SysBus  inout  WIDTH  shared tristate bus
- DataIn  in  WIDTH  memory read data
- MemEn  in  1  drive DataIn onto SysBus
- IrWe  in  1  IR <= SysBus
- Ir  out  WIDTH  instruction register
- AluOp  in  4  ALU function code
- Op1Sel  in  1  0: Rd1, 1: PC
- Op2Sel  in  2  0: Rd2, 1: sext Ir[4:0], 2: sext Ir[7:0], 3: zero
- Rs1Sel  in  1  0: Ir[10:8], 1: Ir[7:5]; Rs2 is always Ir[4:2]
- RwSel  in  2  0: reg 7, 1: Ir[10:8], 2: Ir[7:5], 3: reg 7
- WdSel  in  2  0: ALU result, 1: SysBus, 2: MulLo, 3: MulHi
- RegWe  in  1  register file write enable
- FlagWe  in  1  Flags <= ALU flags
- Flags  out  4  registered {N,Z,C,V}
- PcSel  in  3  0: PC+1, 1: LR, 2: ALU result, 3: SysBus, 4: INT_VECTOR
- PcWe, PcEn  in  1  PC write enable / drive PC onto SysBus
- LrSel  in  1  0: PC+1, 1: SysBus
- LrWe, LrEn  in  1  LR write enable / drive LR onto SysBus
- AluWe, AluEn  in  1  ALUOUT write enable / drive ALUOUT onto SysBus
- IntEnter  in  1  interrupt entry strobe
- IntReturn  in  1  interrupt return strobe
- IntActive  out  1  in interrupt handler
- MulStart  in  1  start multiply
- MulBusy  out  1  multiplier running
- MulDone  out  1  one-cycle completion pulse
- BusConflict  out  1  combinational; high when more than one of MemEn/PcEn/LrEn/AluEn is asserted

Behaviour:
Reset: nReset low asynchronously clears PC, LR, IR, ALUOUT, all registers, Flags, SavedFlags, IntActive, MulLo/MulHi and the multiplier FSM (to IDLE). Outputs are 0 and SysBus is released.

Bus:
- SysBus is driven only by enabled sources; with none enabled it floats (Z).
- BusConflict is asserted on multiple drivers; SysBus contents are then undefined.

Register file:
- Two combinational reads, one write on the clock edge.
- Read-during-write returns the old value.

ALU (combinational):
- AluOp codes: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 LSL A by 1, 9 LSR, 10 ASR, 11 pass B; 12-15 pass A.
- ADC/SBC use the registered Flags.C.
- SUB: A+~B+1; SBC: A+~B+C. C=1 means no borrow.
- N = MSB, Z = (result==0).
- Add/sub: C = carry out, V = signed overflow.
- Shifts: C = bit shifted out, V=0.
- Logic and pass: C=0, V=0.

Registers:
- PC, LR, IR, ALUOUT update only when their We is high.
- PC+1 wraps modulo 2^WIDTH.

Interrupts (priority IntEnter > IntReturn > PcWe/LrWe/FlagWe):
- IntEnter while IntActive=0: LR<=PC, PC<=INT_VECTOR, SavedFlags<=Flags, IntActive<=1, all in one cycle.
- IntEnter while IntActive=1: ignored (no nesting).
- IntReturn while IntActive=1: PC<=LR, Flags<=SavedFlags, IntActive<=0.
- IntReturn while IntActive=0: ignored.
- IntEnter and IntReturn in the same cycle: IntEnter wins when IntActive=0, IntReturn wins when IntActive=1.

Multiplier FSM (IDLE, RUN, DONE):
- IDLE + MulStart: latch Op1/Op2 mux outputs, clear the accumulator, counter<=WIDTH-1, go to RUN.
- RUN: one shift-add step per cycle (unsigned). Leaves RUN after WIDTH cycles and loads MulHi/MulLo with the 2*WIDTH-bit product.
- DONE: lasts one cycle with MulDone=1, then returns to IDLE.
- MulBusy=1 exactly in RUN.
- MulStart in RUN or DONE: ignored.
- Operand registers changing during RUN have no effect.
- Reset mid-operation: abort, MulLo/MulHi cleared.

Optional Feature:
- Macro: DATAPATH_GEN_MUL_EN.
- Defined: the multiplier is built as above.
- Undefined: no multiplier logic; MulBusy=MulDone=0, MulStart ignored, WdSel 2/3 write zero.

Test Plan:
1. Reset then PcWe with PcSel=0 for three cycles -> PC=3. PcEn -> SysBus=16'h0003, BusConflict=0.
2. R1=16'h7FFF, R2=1, AluOp=ADD, FlagWe -> result 16'h8000, Flags N=1 Z=0 C=0 V=1. Then SUB R1,R1 -> Z=1, C=1.
3. PC=16'h0123, Flags=4'b0010, IntEnter -> LR=16'h0123, PC=16'h0010, IntActive=1. Second IntEnter -> no change. IntReturn -> PC=16'h0123, Flags=4'b0010, IntActive=0.
4. With the macro defined, WIDTH=16, Rd1=16'hFFFF, Rd2=16'h0003, MulStart -> MulBusy high 16 cycles, then MulDone pulse, MulHi=16'h0002, MulLo=16'hFFFD. MulStart during RUN ignored.
5. nReset low mid-multiply (cycle 5 of RUN) -> MulBusy=0 immediately, MulLo=MulHi=0, FSM IDLE.
6. MemEn and AluEn both high -> BusConflict=1. Only MemEn high with DataIn=16'hA5A5 and IrWe -> Ir=16'hA5A5.
